// File: rtl/costas_flow_pkg.sv
// Shared state encoding and saturating-counter helper for the Costas-loop flow scheduler.
package costas_flow_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_FIFO = 3'd1,
      ST_PREFILL   = 3'd2,
      ST_RUN       = 3'd3,
      ST_DRAIN     = 3'd4
   } flow_state_e;

   localparam int unsigned SAT_W = 64;

   // Increment that sticks at max_val; callers widen their counter to SAT_W bits.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                input logic [SAT_W-1:0] max_val);
      return (val >= max_val) ? val : val + SAT_W'(1);
   endfunction

endpackage

// File: rtl/flow_valid_delay.sv
// Valid-bit delay line matching the input-FIFO read plus Costas loop pipeline latency.
module flow_valid_delay #(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr;

   // Truncating the concatenation drops the oldest bit, which also covers DEPTH == 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else begin
         sr <= DEPTH'({sr, din});
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/costas_flow_ctrl.sv
// Flow scheduler for ADC -> input FIFO -> Costas loop -> output FIFO -> DAC, with
// latency-aligned output writes, output prefill, DAC read pacing and saturating statistics.
module costas_flow_ctrl
   import costas_flow_pkg::*;
#(
   parameter int unsigned DSP_LATENCY   = 4,
   parameter int unsigned PREFILL_DEPTH = 16,
   parameter int unsigned OUT_RATE_DIV  = 1,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst_in,
   input  logic                 enable,
   input  logic                 clr_stats,
   input  logic                 in_almost_empty,
   input  logic                 in_rd_rst_busy,
   input  logic                 out_almost_full,
   input  logic                 out_almost_empty,
   output logic                 in_rd_en,
   output logic                 dsp_en,
   output logic                 out_wr_en,
   output logic                 out_rd_en,
   output logic [2:0]           state,
   output logic                 running,
   output logic [CNT_WIDTH-1:0] underrun_cnt,
   output logic [CNT_WIDTH-1:0] overflow_cnt
);

   localparam int unsigned DRAIN_W = (DSP_LATENCY > 1) ? $clog2(DSP_LATENCY) : 1;
   localparam int unsigned RATE_W  = (OUT_RATE_DIV > 1) ? $clog2(OUT_RATE_DIV) : 1;
   localparam int unsigned PRE_W   = $clog2(PREFILL_DEPTH + 1);
   localparam logic [SAT_W-1:0] CNT_MAX = (SAT_W'(1) << CNT_WIDTH) - SAT_W'(1);

   flow_state_e        state_q;
   flow_state_e        state_next;
   logic [PRE_W-1:0]   prefill_cnt;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [RATE_W-1:0]  rate_cnt;
   logic               prefill_done;
   logic               drain_done;
   logic               slot;
   logic               underrun_evt;
   logic               overflow_evt;

   assign state = state_q;

   // Reads only while streaming and every FIFO flag permits it.
   assign in_rd_en = ((state_q == ST_PREFILL) || (state_q == ST_RUN)) &&
                     !in_almost_empty && !out_almost_full && !in_rd_rst_busy;
   assign dsp_en   = in_rd_en;

   flow_valid_delay #(
      .DEPTH (DSP_LATENCY)
   ) u_valid_delay (
      .clk   (clk),
      .rst_n (rst_in),
      .din   (in_rd_en),
      .dout  (out_wr_en)
   );

   // The write landing this cycle counts toward prefill, so RUN starts right after it.
   assign prefill_done = (32'(prefill_cnt) + 32'(out_wr_en)) >= 32'(PREFILL_DEPTH);
   assign drain_done   = (drain_cnt == DRAIN_W'(DSP_LATENCY - 1));

   assign slot         = (state_q == ST_RUN) && (rate_cnt == '0);
   assign out_rd_en    = slot && !out_almost_empty;
   assign underrun_evt = slot && out_almost_empty;
   assign overflow_evt = out_wr_en && out_almost_full;

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= ST_IDLE;
         running <= 1'b0;
      end else begin
         state_q <= state_next;
         running <= (state_next == ST_RUN);
      end
   end

   always_comb begin
      state_next = state_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_next = ST_WAIT_FIFO;
         end
         ST_WAIT_FIFO: begin
            if (!enable)              state_next = ST_IDLE;
            else if (!in_rd_rst_busy) state_next = ST_PREFILL;
         end
         ST_PREFILL: begin
            if (!enable)          state_next = ST_DRAIN;
            else if (prefill_done) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_done) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Prefill write counter, restarted whenever a new run request is accepted.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         prefill_cnt <= '0;
      end else if ((state_q == ST_IDLE) && (state_next == ST_WAIT_FIFO)) begin
         prefill_cnt <= '0;
      end else if (out_wr_en && (prefill_cnt < PRE_W'(PREFILL_DEPTH))) begin
         prefill_cnt <= prefill_cnt + PRE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         drain_cnt <= '0;
      end else if (state_q == ST_DRAIN) begin
         drain_cnt <= drain_cnt + DRAIN_W'(1);
      end else begin
         drain_cnt <= '0;
      end
   end

   // DAC slot divider; parked at zero so the first RUN cycle is always a slot.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         rate_cnt <= '0;
      end else if (state_q == ST_RUN) begin
         rate_cnt <= (rate_cnt == RATE_W'(OUT_RATE_DIV - 1)) ? '0 : rate_cnt + RATE_W'(1);
      end else begin
         rate_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         underrun_cnt <= '0;
         overflow_cnt <= '0;
      end else if (clr_stats) begin
         underrun_cnt <= '0;
         overflow_cnt <= '0;
      end else begin
         if (underrun_evt) underrun_cnt <= CNT_WIDTH'(sat_inc(SAT_W'(underrun_cnt), CNT_MAX));
         if (overflow_evt) overflow_cnt <= CNT_WIDTH'(sat_inc(SAT_W'(overflow_cnt), CNT_MAX));
      end
   end

endmodule

// File: tb/tb_costas_flow_ctrl.sv
// Directed bench for costas_flow_ctrl: a per-cycle vector table for the main flow plus
// hand sequences for reset, stats clear, WAIT_FIFO stall and minimum-parameter corners.
module tb_costas_flow_ctrl;

   localparam int NV = 64;

   typedef struct {
      logic       en;
      logic       iae;
      logic       busy;
      logic       oaf;
      logic       oae;
      logic       rd;
      logic       wr;
      logic       ord;
      logic [2:0] st;
      int         und;
      int         ovf;
   } vec_t;

   logic        clk;
   logic        rst_in;
   logic        enable, clr_stats, in_almost_empty, in_rd_rst_busy;
   logic        out_almost_full, out_almost_empty;
   logic        in_rd_en, dsp_en, out_wr_en, out_rd_en, running;
   logic [2:0]  state;
   logic [15:0] underrun_cnt, overflow_cnt;

   logic        b_en, b_clr, b_iae, b_busy, b_oaf, b_oae;
   logic        b_rd, b_dsp, b_wr, b_ord, b_run;
   logic [2:0]  b_st;
   logic [1:0]  b_und, b_ovf;

   int   n_cmp;
   int   n_err;
   vec_t tbl [NV];

   costas_flow_ctrl #(
      .DSP_LATENCY   (4),
      .PREFILL_DEPTH (16),
      .OUT_RATE_DIV  (3),
      .CNT_WIDTH     (16)
   ) dut (
      .clk              (clk),
      .rst_in           (rst_in),
      .enable           (enable),
      .clr_stats        (clr_stats),
      .in_almost_empty  (in_almost_empty),
      .in_rd_rst_busy   (in_rd_rst_busy),
      .out_almost_full  (out_almost_full),
      .out_almost_empty (out_almost_empty),
      .in_rd_en         (in_rd_en),
      .dsp_en           (dsp_en),
      .out_wr_en        (out_wr_en),
      .out_rd_en        (out_rd_en),
      .state            (state),
      .running          (running),
      .underrun_cnt     (underrun_cnt),
      .overflow_cnt     (overflow_cnt)
   );

   costas_flow_ctrl #(
      .DSP_LATENCY   (1),
      .PREFILL_DEPTH (1),
      .OUT_RATE_DIV  (1),
      .CNT_WIDTH     (2)
   ) dut_min (
      .clk              (clk),
      .rst_in           (rst_in),
      .enable           (b_en),
      .clr_stats        (b_clr),
      .in_almost_empty  (b_iae),
      .in_rd_rst_busy   (b_busy),
      .out_almost_full  (b_oaf),
      .out_almost_empty (b_oae),
      .in_rd_en         (b_rd),
      .dsp_en           (b_dsp),
      .out_wr_en        (b_wr),
      .out_rd_en        (b_ord),
      .state            (b_st),
      .running          (b_run),
      .underrun_cnt     (b_und),
      .overflow_cnt     (b_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".state"}, 32'(state), 32'd0);
      chk({tag, ".in_rd_en"}, 32'(in_rd_en), 32'd0);
      chk({tag, ".dsp_en"}, 32'(dsp_en), 32'd0);
      chk({tag, ".out_wr_en"}, 32'(out_wr_en), 32'd0);
      chk({tag, ".out_rd_en"}, 32'(out_rd_en), 32'd0);
      chk({tag, ".running"}, 32'(running), 32'd0);
      chk({tag, ".underrun"}, 32'(underrun_cnt), 32'd0);
      chk({tag, ".overflow"}, 32'(overflow_cnt), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int und_acc;
      int ovf_acc;
      int k;

      n_cmp = 0;
      n_err = 0;

      // Cycle map: enable from 1, WAIT 2, PREFILL 3..22, RUN 23..57, DRAIN 58..61, IDLE 62+.
      und_acc = 0;
      ovf_acc = 0;
      for (int c = 0; c < NV; c++) begin
         tbl[c].en   = ((c >= 1) && (c <= 56)) || ((c >= 59) && (c <= 61));
         tbl[c].iae  = (c == 27);
         tbl[c].busy = (c == 29);
         tbl[c].oaf  = (c >= 48) && (c <= 55);
         tbl[c].oae  = (c >= 32) && (c <= 46);
         if (c <= 1)       tbl[c].st = 3'd0;
         else if (c == 2)  tbl[c].st = 3'd1;
         else if (c <= 22) tbl[c].st = 3'd2;
         else if (c <= 57) tbl[c].st = 3'd3;
         else if (c <= 61) tbl[c].st = 3'd4;
         else              tbl[c].st = 3'd0;
         tbl[c].rd  = (c >= 3) && (c <= 57) && !tbl[c].oaf && !tbl[c].iae && !tbl[c].busy;
         tbl[c].wr  = (c >= 4) ? tbl[c-4].rd : 1'b0;
         tbl[c].ord = (tbl[c].st == 3'd3) && (((c - 23) % 3) == 0) && !tbl[c].oae;
         tbl[c].und = und_acc;
         tbl[c].ovf = ovf_acc;
         if ((tbl[c].st == 3'd3) && (((c - 23) % 3) == 0) && tbl[c].oae) und_acc++;
         if (tbl[c].wr && tbl[c].oaf) ovf_acc++;
      end

      rst_in = 1'b0;
      enable = 1'b0; clr_stats = 1'b0; in_almost_empty = 1'b0; in_rd_rst_busy = 1'b0;
      out_almost_full = 1'b0; out_almost_empty = 1'b0;
      b_en = 1'b0; b_clr = 1'b0; b_iae = 1'b0; b_busy = 1'b0; b_oaf = 1'b0; b_oae = 1'b0;

      @(negedge clk);
      #1;
      chk_all_zero("rst");
      chk("rst.min_state", 32'(b_st), 32'd0);
      @(negedge clk);
      rst_in = 1'b1;

      for (int c = 0; c < NV; c++) begin
         @(negedge clk);
         enable           = tbl[c].en;
         in_almost_empty  = tbl[c].iae;
         in_rd_rst_busy   = tbl[c].busy;
         out_almost_full  = tbl[c].oaf;
         out_almost_empty = tbl[c].oae;
         #1;
         chk($sformatf("v%0d.state", c), 32'(state), 32'(tbl[c].st));
         chk($sformatf("v%0d.running", c), 32'(running), 32'(tbl[c].st == 3'd3));
         chk($sformatf("v%0d.in_rd_en", c), 32'(in_rd_en), 32'(tbl[c].rd));
         chk($sformatf("v%0d.dsp_en", c), 32'(dsp_en), 32'(tbl[c].rd));
         chk($sformatf("v%0d.out_wr_en", c), 32'(out_wr_en), 32'(tbl[c].wr));
         chk($sformatf("v%0d.out_rd_en", c), 32'(out_rd_en), 32'(tbl[c].ord));
         chk($sformatf("v%0d.underrun", c), 32'(underrun_cnt), 32'(tbl[c].und));
         chk($sformatf("v%0d.overflow", c), 32'(overflow_cnt), 32'(tbl[c].ovf));
      end

      // Stats clear pulse from IDLE.
      @(negedge clk);
      enable = 1'b0;
      clr_stats = 1'b1;
      #1;
      chk("clr.before_und", 32'(underrun_cnt), 32'd5);
      chk("clr.before_ovf", 32'(overflow_cnt), 32'd4);
      @(negedge clk);
      clr_stats = 1'b0;
      #1;
      chk("clr.und", 32'(underrun_cnt), 32'd0);
      chk("clr.ovf", 32'(overflow_cnt), 32'd0);

      // Async reset mid-PREFILL with the delay line full.
      @(negedge clk);
      enable = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      chk("mid.state", 32'(state), 32'd2);
      chk("mid.out_wr_en", 32'(out_wr_en), 32'd1);
      #2;
      rst_in = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst_in = 1'b1;
      enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post_rst%0d.out_wr_en", i), 32'(out_wr_en), 32'd0);
         chk($sformatf("post_rst%0d.state", i), 32'(state), 32'd0);
      end

      // WAIT_FIFO stall on rd_rst_busy, then clear racing an underrun on the first slot.
      @(negedge clk);
      enable = 1'b1;
      in_rd_rst_busy = 1'b1;
      k = 41;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 3) in_rd_rst_busy = 1'b0;
         #1;
         if (i == 2) chk("busy.wait_state", 32'(state), 32'd1);
         if (state == 3'd3) begin
            k = i;
            break;
         end
      end
      chk("busy.run_latency", 32'(k), 32'd24);
      chk("run.first_slot", 32'(out_rd_en), 32'd1);
      out_almost_empty = 1'b1;
      clr_stats = 1'b1;
      #1;
      chk("race.out_rd_en", 32'(out_rd_en), 32'd0);
      @(negedge clk);
      clr_stats = 1'b0;
      #1;
      chk("race.underrun", 32'(underrun_cnt), 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("slot3.out_rd_en", 32'(out_rd_en), 32'd0);
      chk("slot3.underrun_pre", 32'(underrun_cnt), 32'd0);
      @(negedge clk);
      #1;
      chk("slot3.underrun", 32'(underrun_cnt), 32'd1);
      enable = 1'b0;
      out_almost_empty = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      chk("end.state", 32'(state), 32'd0);

      // Minimum parameters: latency 1, prefill 1, slot every cycle, 2-bit saturating stats.
      @(negedge clk);
      b_en = 1'b1;
      @(negedge clk);
      #1;
      chk("min1.state", 32'(b_st), 32'd1);
      @(negedge clk);
      #1;
      chk("min2.state", 32'(b_st), 32'd2);
      chk("min2.in_rd_en", 32'(b_rd), 32'd1);
      chk("min2.dsp_en", 32'(b_dsp), 32'd1);
      chk("min2.out_wr_en", 32'(b_wr), 32'd0);
      @(negedge clk);
      b_oae = 1'b1;
      #1;
      chk("min3.state", 32'(b_st), 32'd2);
      chk("min3.out_wr_en", 32'(b_wr), 32'd1);
      @(negedge clk);
      #1;
      chk("min4.state", 32'(b_st), 32'd3);
      chk("min4.running", 32'(b_run), 32'd1);
      chk("min4.out_rd_en", 32'(b_ord), 32'd0);
      chk("min4.underrun", 32'(b_und), 32'd0);
      repeat (4) @(negedge clk);
      #1;
      chk("min8.underrun", 32'(b_und), 32'd3);
      @(negedge clk);
      b_oae = 1'b0;
      b_en = 1'b0;
      #1;
      chk("min9.underrun_sat", 32'(b_und), 32'd3);
      chk("min9.out_rd_en", 32'(b_ord), 32'd1);
      @(negedge clk);
      #1;
      chk("min10.state", 32'(b_st), 32'd4);
      chk("min10.out_wr_en", 32'(b_wr), 32'd1);
      chk("min10.in_rd_en", 32'(b_rd), 32'd0);
      chk("min10.out_rd_en", 32'(b_ord), 32'd0);
      @(negedge clk);
      #1;
      chk("min11.state", 32'(b_st), 32'd0);
      chk("min11.out_wr_en", 32'(b_wr), 32'd0);
      chk("min11.overflow", 32'(b_ovf), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/costas_flow_ctrl.md
# costas_flow_ctrl

Flow scheduler for the ADC→input FIFO→COSTAS_LOOP→output FIFO→DAC chain. It owns the input-FIFO read enable and the DSP enable. It aligns the output-FIFO write strobe with the Costas loop pipeline latency, prefills the output FIFO before the DAC starts consuming, and paces DAC reads. It also keeps saturating underrun/overflow statistics for the ILA.

## Interface
Parameters:
- DSP_LATENCY, 4: cycles from in_rd_en to valid COSTAS_LOOP output, input-FIFO read latency included; legal range 1–32.
- PREFILL_DEPTH, 16: output-FIFO writes required before DAC reads start; must be ≥1.
- OUT_RATE_DIV, 1: one DAC read slot every OUT_RATE_DIV cycles; must be ≥1.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock (clk_wiz output).
- rst_in  in  1  asynchronous, active-low reset.
- enable  in  1  run request, level.
- clr_stats  in  1  synchronous pulse; clears both statistics counters.
- in_almost_empty  in  1  input FIFO almost_empty.
- in_rd_rst_busy  in  1  input FIFO rd_rst_busy.
- out_almost_full  in  1  output FIFO almost_full.
- out_almost_empty  in  1  output FIFO almost_empty.
- in_rd_en  out  1  input FIFO rd_en.
- dsp_en  out  1  equals in_rd_en.
- out_wr_en  out  1  output FIFO wr_en, delayed by DSP_LATENCY.
- out_rd_en  out  1  output FIFO rd_en toward the DAC path.
- state  out  3  current FSM state code.
- running  out  1  high in RUN.
- underrun_cnt  out  CNT_WIDTH  skipped DAC read slots, saturating.
- overflow_cnt  out  CNT_WIDTH  writes issued while out_almost_full, saturating.

## Operation
- FSM states: IDLE=0, WAIT_FIFO=1, PREFILL=2, RUN=3, DRAIN=4.
- IDLE→WAIT_FIFO when enable=1.
- WAIT_FIFO→PREFILL when in_rd_rst_busy=0.
- PREFILL→RUN when prefill_cnt reaches PREFILL_DEPTH. prefill_cnt counts out_wr_en pulses.
- From PREFILL or RUN, enable=0 → DRAIN. DRAIN→IDLE after DSP_LATENCY cycles. enable is ignored while in DRAIN.
- From WAIT_FIFO, enable=0 → IDLE.
- in_rd_en = (state∈{PREFILL,RUN}) & !in_almost_empty & !out_almost_full & !in_rd_rst_busy. This is combinational from the registered state and the FIFO flags.
- Valid delay line of DSP_LATENCY registers: out_wr_en(t) = in_rd_en(t−DSP_LATENCY). Entries already in flight keep shifting in DRAIN and are written.
- Rate divider rate_cnt counts 0..OUT_RATE_DIV−1 and wraps. It is held at 0 outside RUN and restarts at 0 on RUN entry. A slot occurs when rate_cnt=0 in RUN.
- At a slot: if !out_almost_empty, out_rd_en=1. Otherwise out_rd_en=0, underrun_cnt increments, and the slot is lost (no retry).
- Any cycle with out_wr_en=1 & out_almost_full=1 increments overflow_cnt.
- Statistics counters saturate at 2^CNT_WIDTH−1. If clr_stats and an increment occur in the same cycle, the clear wins.
- prefill_cnt clears on entry to WAIT_FIFO and saturates at PREFILL_DEPTH.

## Timing
- On reset, every output is 0: state=IDLE, delay line, all counters, out_rd_en and running.
- Reset takes effect immediately mid-operation. In-flight valids are discarded and no out_wr_en is issued after reset.
- enable sampled high at edge k gives WAIT_FIFO at k+1. With busy=0, PREFILL at k+2. The earliest in_rd_en is at k+2.
- in_rd_en at cycle t gives out_wr_en at exactly t+DSP_LATENCY.
- The PREFILL_DEPTH-th out_wr_en at cycle t gives RUN at t+1 and the first out_rd_en slot at t+1.
- out_rd_en never asserts outside RUN. In DRAIN it is 0 from the first DRAIN cycle.
- running is registered together with state.

## Structure
- Package costas_flow_pkg holds:
  - the state encoding constants (IDLE..DRAIN, 3 bits);
  - a saturating-increment function shared by both counters.
- Sub-module flow_valid_delay: a parameterised 1-bit shift register of depth DSP_LATENCY with asynchronous active-low clear. It provides the out_wr_en path and the DRAIN countdown reference.
- All other logic lives in costas_flow_ctrl.

## Test plan
- Reset then enable=1, in_almost_empty=0, flags clear, DSP_LATENCY=4, PREFILL_DEPTH=16 → first in_rd_en 2 cycles after enable; first out_wr_en 4 cycles later; RUN entered the cycle after the 16th out_wr_en.
- RUN, OUT_RATE_DIV=3, out_almost_empty=0 → out_rd_en on every third cycle starting at the first RUN cycle; underrun_cnt stays 0.
- RUN, out_almost_empty=1 for 5 slots → no out_rd_en during that window; underrun_cnt=5.
- Hold out_almost_full=1 while 4 reads are in flight → in_rd_en drops the same cycle; the 4 in-flight out_wr_en still fire; overflow_cnt=4.
- enable=0 during RUN → next state DRAIN; in_rd_en and out_rd_en are 0; in-flight out_wr_en fire; IDLE after 4 cycles.
- rst_in pulsed low mid-PREFILL with a full delay line → all outputs 0 asynchronously; no out_wr_en after release; clr_stats asserted in the same cycle as an underrun leaves underrun_cnt=0.
